// File: rtl/data_bridge_rd_reorder_pkg.sv
// Shared encodings for the read reorder bridge: response codes, half-select
// positions and FIR bit indices.
package data_bridge_rd_reorder_pkg;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    localparam logic [1:0] POS_LO   = 2'b01;
    localparam logic [1:0] POS_HI   = 2'b10;
    localparam logic [1:0] POS_FULL = 2'b11;

    localparam logic [2:0] DMA_CODE_OK = 3'd0;

    localparam int unsigned FIR_W       = 2;
    localparam int unsigned FIR_UNALLOC = 0;
    localparam int unsigned FIR_DUP     = 1;

    // On a 512-bit bus a single low-half beat carries the whole word.
    function automatic logic [1:0] eff_pos(input logic [1:0] pos, input logic narrow);
        if (narrow) begin
            return pos[0] ? POS_FULL : 2'b00;
        end
        return pos;
    endfunction

endpackage

// File: rtl/dbr_tag_ram.sv
// Per-tag read data buffer: simple dual-port RAM split into two half-width
// lanes with independent write enables, registered read port.
module dbr_tag_ram #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_lo,
    input  logic          we_hi,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned HW    = DW / 2;
    localparam int unsigned DEPTH = 2 ** AW;

    logic [HW-1:0] mem_lo [DEPTH];
    logic [HW-1:0] mem_hi [DEPTH];

    always_ff @(posedge clk) begin
        if (we_lo) begin
            mem_lo[waddr] <= wdata[HW-1:0];
        end
        if (we_hi) begin
            mem_hi[waddr] <= wdata[DW-1:HW];
        end
    end

    // Read register only advances on a read, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= {mem_hi[raddr], mem_lo[raddr]};
        end
    end

endmodule

// File: rtl/data_bridge_rd_reorder.sv
// Read-side bridge channel: issues tagged DMA read commands for local requests
// and returns out-of-order, possibly split, responses strictly in request order.
module data_bridge_rd_reorder
    import data_bridge_rd_reorder_pkg::*;
#(
    parameter int unsigned IDW     = 3,
    parameter int unsigned TAGW    = 6,
    parameter int unsigned DW      = 1024,
    parameter int unsigned MAX_OUT = 2 ** TAGW
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              lcl_addr_valid,
    output logic              lcl_addr_ready,
    input  logic [63:0]       lcl_addr_ea,
    input  logic [IDW-1:0]    lcl_addr_axi_id,
    input  logic [DW/8-1:0]   lcl_addr_be,
    input  logic              lcl_addr_last,

    output logic              lcl_resp_valid,
    input  logic              lcl_resp_ready,
    output logic [DW-1:0]     lcl_resp_data,
    output logic [IDW-1:0]    lcl_resp_axi_id,
    output logic              lcl_resp_last,
    output logic              lcl_resp_code,

    output logic              dma_cmd_valid,
    input  logic              dma_cmd_ready,
    output logic [63:0]       dma_cmd_ea,
    output logic [DW/8-1:0]   dma_cmd_be,
    output logic [TAGW-1:0]   dma_cmd_tag,

    input  logic              dma_resp_valid,
    input  logic [TAGW-1:0]   dma_resp_tag,
    input  logic [DW-1:0]     dma_resp_data,
    input  logic [1:0]        dma_resp_pos,
    input  logic [2:0]        dma_resp_code,

    input  logic              context_update_ongoing,
    output logic              buf_empty,
    output logic [TAGW:0]     outstanding_cnt,
    output logic [FIR_W-1:0]  fir
);

    localparam int unsigned DEPTH  = 2 ** TAGW;
    localparam int unsigned CNTW   = TAGW + 1;
    localparam logic        NARROW = (DW == 512);

    logic [TAGW-1:0] head;
    logic [TAGW-1:0] tail;
    logic [CNTW-1:0] cnt;

    logic [DEPTH-1:0] ent_alloc;
    logic [DEPTH-1:0] ent_err;
    logic [DEPTH-1:0] ent_last;
    logic [1:0]       ent_got [DEPTH];
    logic [IDW-1:0]   ent_id  [DEPTH];

    logic       accept;
    logic [1:0] resp_pos;
    logic       resp_alloc;
    logic       resp_hit;
    logic       resp_dup;
    logic       resp_orphan;
    logic       resp_err;
    logic       tail_done;
    logic       out_free;
    logic       drain;

    // Request admission: credit available, no context switch, cmd slot free.
    assign lcl_addr_ready = (cnt < CNTW'(MAX_OUT)) && !context_update_ongoing &&
                            (!dma_cmd_valid || dma_cmd_ready);
    assign accept         = lcl_addr_valid && lcl_addr_ready;

    assign resp_pos    = eff_pos(dma_resp_pos, NARROW);
    assign resp_alloc  = ent_alloc[dma_resp_tag];
    assign resp_hit    = dma_resp_valid && resp_alloc;
    assign resp_orphan = dma_resp_valid && !resp_alloc;
    assign resp_dup    = resp_hit && ((ent_got[dma_resp_tag] & resp_pos) != 2'b00);
    assign resp_err    = (dma_resp_code != DMA_CODE_OK);

    // Drain decision uses registered entry state only; no response bypass.
    assign tail_done = ent_alloc[tail] && (ent_got[tail] == POS_FULL);
    assign out_free  = !lcl_resp_valid || lcl_resp_ready;
    assign drain     = tail_done && out_free;

    assign buf_empty       = (cnt == '0) && !lcl_resp_valid && !dma_cmd_valid;
    assign outstanding_cnt = cnt;

    // Entry control bits; a same-cycle allocation overrides drain/response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_alloc <= '0;
            ent_err   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_got[i] <= 2'b00;
            end
        end else begin
            if (resp_hit) begin
                ent_got[dma_resp_tag] <= ent_got[dma_resp_tag] | resp_pos;
                ent_err[dma_resp_tag] <= ent_err[dma_resp_tag] | resp_err;
            end
            if (drain) begin
                ent_alloc[tail] <= 1'b0;
            end
            if (accept) begin
                ent_alloc[head] <= 1'b1;
                ent_got[head]   <= 2'b00;
                ent_err[head]   <= 1'b0;
            end
        end
    end

    // Per-entry request payload; only meaningful while the entry is allocated.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_id[head]   <= lcl_addr_axi_id;
            ent_last[head] <= lcl_addr_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (accept) begin
                head <= head + TAGW'(1);
            end
            if (drain) begin
                tail <= tail + TAGW'(1);
            end
            if (accept && !drain) begin
                cnt <= cnt + CNTW'(1);
            end else if (!accept && drain) begin
                cnt <= cnt - CNTW'(1);
            end
        end
    end

    // DMA command register, held until the encoder takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_cmd_valid <= 1'b0;
            dma_cmd_ea    <= '0;
            dma_cmd_be    <= '0;
            dma_cmd_tag   <= '0;
        end else if (accept) begin
            dma_cmd_valid <= 1'b1;
            dma_cmd_ea    <= lcl_addr_ea;
            dma_cmd_be    <= lcl_addr_be;
            dma_cmd_tag   <= head;
        end else if (dma_cmd_ready) begin
            dma_cmd_valid <= 1'b0;
        end
    end

    // Local response stage; data comes straight from the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcl_resp_valid  <= 1'b0;
            lcl_resp_axi_id <= '0;
            lcl_resp_last   <= 1'b0;
            lcl_resp_code   <= RESP_OKAY;
        end else if (drain) begin
            lcl_resp_valid  <= 1'b1;
            lcl_resp_axi_id <= ent_id[tail];
            lcl_resp_last   <= ent_last[tail];
            lcl_resp_code   <= ent_err[tail] ? RESP_SLVERR : RESP_OKAY;
        end else if (lcl_resp_ready) begin
            lcl_resp_valid  <= 1'b0;
        end
    end

    // Sticky error capture, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fir <= '0;
        end else begin
            if (resp_orphan) begin
                fir[FIR_UNALLOC] <= 1'b1;
            end
            if (resp_dup) begin
                fir[FIR_DUP] <= 1'b1;
            end
        end
    end

    dbr_tag_ram #(
        .AW (TAGW),
        .DW (DW)
    ) u_tag_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we_lo (resp_hit && ((resp_pos & POS_LO) != 2'b00)),
        .we_hi (resp_hit && ((resp_pos & POS_HI) != 2'b00)),
        .waddr (dma_resp_tag),
        .wdata (dma_resp_data),
        .re    (drain),
        .raddr (tail),
        .rdata (lcl_resp_data)
    );

endmodule

// File: tb/tb_data_bridge_rd_reorder.sv
// Scoreboard bench for the read reorder bridge: directed scenarios followed by
// randomized out-of-order split responses under random backpressure.
module tb_data_bridge_rd_reorder;

    localparam int unsigned IDW     = 3;
    localparam int unsigned TAGW    = 4;
    localparam int unsigned DW      = 1024;
    localparam int unsigned MAX_OUT = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned BEW     = DW / 8;
    localparam int unsigned HW      = DW / 2;
    localparam int          NRAND   = 200;

    logic            clk;
    logic            rst_n;
    logic            lcl_addr_valid;
    logic            lcl_addr_ready;
    logic [63:0]     lcl_addr_ea;
    logic [IDW-1:0]  lcl_addr_axi_id;
    logic [BEW-1:0]  lcl_addr_be;
    logic            lcl_addr_last;
    logic            lcl_resp_valid;
    logic            lcl_resp_ready;
    logic [DW-1:0]   lcl_resp_data;
    logic [IDW-1:0]  lcl_resp_axi_id;
    logic            lcl_resp_last;
    logic            lcl_resp_code;
    logic            dma_cmd_valid;
    logic            dma_cmd_ready;
    logic [63:0]     dma_cmd_ea;
    logic [BEW-1:0]  dma_cmd_be;
    logic [TAGW-1:0] dma_cmd_tag;
    logic            dma_resp_valid;
    logic [TAGW-1:0] dma_resp_tag;
    logic [DW-1:0]   dma_resp_data;
    logic [1:0]      dma_resp_pos;
    logic [2:0]      dma_resp_code;
    logic            context_update_ongoing;
    logic            buf_empty;
    logic [TAGW:0]   outstanding_cnt;
    logic [1:0]      fir;

    data_bridge_rd_reorder #(
        .IDW(IDW), .TAGW(TAGW), .DW(DW), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lcl_addr_valid(lcl_addr_valid), .lcl_addr_ready(lcl_addr_ready),
        .lcl_addr_ea(lcl_addr_ea), .lcl_addr_axi_id(lcl_addr_axi_id),
        .lcl_addr_be(lcl_addr_be), .lcl_addr_last(lcl_addr_last),
        .lcl_resp_valid(lcl_resp_valid), .lcl_resp_ready(lcl_resp_ready),
        .lcl_resp_data(lcl_resp_data), .lcl_resp_axi_id(lcl_resp_axi_id),
        .lcl_resp_last(lcl_resp_last), .lcl_resp_code(lcl_resp_code),
        .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
        .dma_cmd_ea(dma_cmd_ea), .dma_cmd_be(dma_cmd_be), .dma_cmd_tag(dma_cmd_tag),
        .dma_resp_valid(dma_resp_valid), .dma_resp_tag(dma_resp_tag),
        .dma_resp_data(dma_resp_data), .dma_resp_pos(dma_resp_pos),
        .dma_resp_code(dma_resp_code),
        .context_update_ongoing(context_update_ongoing),
        .buf_empty(buf_empty), .outstanding_cnt(outstanding_cnt), .fir(fir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             seq;
        logic [TAGW-1:0] tag;
        logic [IDW-1:0] id;
        logic           last;
    } beat_t;

    typedef struct {
        logic [63:0]     ea;
        logic [BEW-1:0]  be;
        logic [TAGW-1:0] tag;
    } cmd_t;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [1:0]      rem;
    } pend_t;

    // Reference model: request-ordered queue plus per-request merged data.
    beat_t           exp_q[$];
    cmd_t            cmd_q[$];
    pend_t           pend[$];
    logic [DW-1:0]   exp_data [int];
    logic            exp_err  [int];
    int              tag_seq  [DEPTH];
    logic            m_alloc  [DEPTH];
    logic [1:0]      m_got    [DEPTH];
    logic [TAGW-1:0] m_head;
    logic [1:0]      exp_fir;
    int              seq_n;

    int   vec_cnt;
    int   miss_cnt;
    logic bp_en;
    logic hold_rready;
    logic issue_done;

    logic            held;
    logic [DW-1:0]   held_data;
    logic [IDW+1:0]  held_ctl;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            for (int i = 0; i < int'(DW / 32); i++) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %08h expected %08h",
                             name, i, act[i*32 +: 32], exp[i*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(DW / 32); i++) begin
            d[i*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        cmd_q.delete();
        pend.delete();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_alloc[i] = 1'b0;
            m_got[i]   = 2'b00;
            tag_seq[i] = -1;
        end
        m_head  = '0;
        exp_fir = 2'b00;
    endtask

    task automatic model_resp(input logic [TAGW-1:0] tag, input logic [1:0] pos,
                              input logic [2:0] code, input logic [DW-1:0] d);
        int            s;
        logic [DW-1:0] cur;
        if (!m_alloc[tag]) begin
            exp_fir[0] = 1'b1;
            return;
        end
        s = tag_seq[tag];
        if ((m_got[tag] & pos) != 2'b00) exp_fir[1] = 1'b1;
        cur = exp_data[s];
        if (pos[0]) cur[HW-1:0]  = d[HW-1:0];
        if (pos[1]) cur[DW-1:HW] = d[DW-1:HW];
        exp_data[s] = cur;
        m_got[tag]  = m_got[tag] | pos;
        if (code != 3'd0) exp_err[s] = 1'b1;
    endtask

    task automatic issue(input logic [IDW-1:0] id, input logic last,
                         input logic [63:0] ea, input logic [BEW-1:0] be);
        bit ok = 1'b0;
        @(posedge clk); #1;
        lcl_addr_valid  = 1'b1;
        lcl_addr_axi_id = id;
        lcl_addr_last   = last;
        lcl_addr_ea     = ea;
        lcl_addr_be     = be;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (lcl_addr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back('{seq_n, m_head, id, last});
            cmd_q.push_back('{ea, be, m_head});
            pend.push_back('{m_head, 2'b11});
            tag_seq[m_head] = seq_n;
            m_alloc[m_head] = 1'b1;
            m_got[m_head]   = 2'b00;
            exp_data[seq_n] = '0;
            exp_err[seq_n]  = 1'b0;
            seq_n++;
            m_head++;
        end else begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL issue_timeout: got ready 0 expected ready 1 within 400 cycles");
        end
        @(posedge clk); #1;
        lcl_addr_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [TAGW-1:0] tag, input logic [1:0] pos,
                             input logic [2:0] code, input logic [DW-1:0] d);
        @(posedge clk); #1;
        dma_resp_valid = 1'b1;
        dma_resp_tag   = tag;
        dma_resp_pos   = pos;
        dma_resp_code  = code;
        dma_resp_data  = d;
        model_resp(tag, pos, code, d);
        @(posedge clk); #1;
        dma_resp_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (buf_empty && exp_q.size() == 0 && cmd_q.size() == 0) break;
        end
        chk({name, "_empty"}, 128'(buf_empty), 128'(1));
        chk({name, "_pending"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_resp_valid"}, 128'(lcl_resp_valid), 128'(0));
        chk({p, "_cmd_valid"},  128'(dma_cmd_valid), 128'(0));
        chk({p, "_buf_empty"},  128'(buf_empty), 128'(1));
        chk({p, "_cnt"},        128'(outstanding_cnt), 128'(0));
        chk({p, "_fir"},        128'(fir), 128'(0));
        chk({p, "_resp_data"},  128'(|lcl_resp_data), 128'(0));
        chk({p, "_cmd_ea"},     128'(dma_cmd_ea), 128'(0));
        chk({p, "_cmd_tag"},    128'(dma_cmd_tag), 128'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n          = 1'b0;
        lcl_addr_valid = 1'b0;
        dma_resp_valid = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Handshake partners: random or forced readiness, updated after each edge.
    always @(posedge clk) begin
        #1;
        dma_cmd_ready  = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        lcl_resp_ready = hold_rready ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
    end

    // Command monitor.
    always @(negedge clk) begin
        cmd_t c;
        if (rst_n && dma_cmd_valid && dma_cmd_ready) begin
            if (cmd_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL cmd_unexpected: got tag %0h expected no command", dma_cmd_tag);
            end else begin
                c = cmd_q.pop_front();
                chk("cmd_tag", 128'(dma_cmd_tag), 128'(c.tag));
                chk("cmd_ea",  128'(dma_cmd_ea), 128'(c.ea));
                chk("cmd_be",  128'(dma_cmd_be), 128'(c.be));
            end
        end
    end

    // Response monitor: in-order scoreboard plus hold-stability under stall.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n && lcl_resp_valid) begin
            if (held) begin
                chk_data("hold_data", lcl_resp_data, held_data);
                chk("hold_ctl", 128'({lcl_resp_axi_id, lcl_resp_last, lcl_resp_code}), 128'(held_ctl));
            end
            if (lcl_resp_ready) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    miss_cnt++;
                    $display("FAIL beat_unexpected: got id %0h expected no beat", lcl_resp_axi_id);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_id",   128'(lcl_resp_axi_id), 128'(b.id));
                    chk("beat_last", 128'(lcl_resp_last), 128'(b.last));
                    chk("beat_code", 128'(lcl_resp_code), 128'(exp_err[b.seq]));
                    chk_data("beat_data", lcl_resp_data, exp_data[b.seq]);
                    if (tag_seq[b.tag] == b.seq) m_alloc[b.tag] = 1'b0;
                end
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = lcl_resp_data;
                held_ctl  = {lcl_resp_axi_id, lcl_resp_last, lcl_resp_code};
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        vec_cnt = 0;
        miss_cnt = 0;
        seq_n = 0;
        held = 1'b0;
        held_data = '0;
        held_ctl = '0;
        bp_en = 1'b0;
        hold_rready = 1'b0;
        issue_done = 1'b0;
        rst_n = 1'b0;
        lcl_addr_valid = 1'b0;
        lcl_addr_ea = '0;
        lcl_addr_axi_id = '0;
        lcl_addr_be = '0;
        lcl_addr_last = 1'b0;
        lcl_resp_ready = 1'b1;
        dma_cmd_ready = 1'b1;
        dma_resp_valid = 1'b0;
        dma_resp_tag = '0;
        dma_resp_data = '0;
        dma_resp_pos = 2'b00;
        dma_resp_code = 3'd0;
        context_update_ongoing = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Single request, single full response.
        issue(3'd5, 1'b1, 64'h1000, '1);
        send_resp(4'd0, 2'b11, 3'd0, rand_data());
        wait_idle("single");

        // Four requests answered 3,1,0,2.
        do_reset();
        for (int i = 0; i < 4; i++) issue(IDW'(i + 1), (i == 3), 64'h2000 + 64'(i * 128), '1);
        send_resp(4'd3, 2'b11, 3'd0, rand_data());
        send_resp(4'd1, 2'b11, 3'd0, rand_data());
        send_resp(4'd0, 2'b11, 3'd0, rand_data());
        send_resp(4'd2, 2'b11, 3'd0, rand_data());
        wait_idle("reorder");

        // Split response, high half first; check completion latency.
        do_reset();
        issue(3'd2, 1'b1, 64'h3000, '1);
        send_resp(4'd0, 2'b10, 3'd0, rand_data());
        chk("split_half_valid", 128'(lcl_resp_valid), 128'(0));
        repeat (2) @(posedge clk);
        send_resp(4'd0, 2'b01, 3'd0, rand_data());
        chk("split_early", 128'(lcl_resp_valid), 128'(0));
        @(posedge clk); #1;
        chk("split_latency", 128'(lcl_resp_valid), 128'(1));
        wait_idle("split");

        // Credit limit and context-update blocking.
        do_reset();
        for (int i = 0; i < int'(MAX_OUT); i++) issue(IDW'(i), 1'b0, 64'h4000 + 64'(i), '1);
        @(negedge clk);
        chk("full_cnt", 128'(outstanding_cnt), 128'(MAX_OUT));
        chk("full_ready", 128'(lcl_addr_ready), 128'(0));
        @(posedge clk); #1;
        lcl_addr_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcl_addr_valid = 1'b0;
        chk("full_no_accept", 128'(outstanding_cnt), 128'(MAX_OUT));
        send_resp(4'd0, 2'b11, 3'd0, rand_data());
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain_cnt", 128'(outstanding_cnt), 128'(MAX_OUT - 1));
        chk("drain_ready", 128'(lcl_addr_ready), 128'(1));
        context_update_ongoing = 1'b1;
        @(negedge clk);
        chk("ctx_ready", 128'(lcl_addr_ready), 128'(0));
        context_update_ongoing = 1'b0;
        for (int i = 1; i < int'(MAX_OUT); i++) send_resp(TAGW'(i), 2'b11, 3'd0, rand_data());
        wait_idle("full");

        // Error code propagation and unallocated-tag FIR.
        do_reset();
        for (int i = 0; i < 3; i++) issue(IDW'(i), (i == 2), 64'h5000, '1);
        send_resp(4'd1, 2'b11, 3'd2, rand_data());
        send_resp(4'd0, 2'b11, 3'd0, rand_data());
        send_resp(4'd2, 2'b11, 3'd0, rand_data());
        send_resp(4'd7, 2'b11, 3'd0, rand_data());
        wait_idle("err");
        chk("fir_unalloc", 128'(fir), 128'(exp_fir));

        // Duplicate half overwrites data and sets FIR.
        do_reset();
        issue(3'd6, 1'b1, 64'h6000, '1);
        send_resp(4'd0, 2'b01, 3'd0, rand_data());
        send_resp(4'd0, 2'b01, 3'd0, rand_data());
        send_resp(4'd0, 2'b10, 3'd0, rand_data());
        wait_idle("dup");
        chk("fir_dup", 128'(fir), 128'(exp_fir));

        // Backpressure with all buffer entries complete.
        do_reset();
        hold_rready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < int'(MAX_OUT); i++) issue(IDW'(i), (i == 7), 64'h7000 + 64'(i), '1);
        for (int i = int'(MAX_OUT) - 1; i >= 0; i--) send_resp(TAGW'(i), 2'b11, 3'd0, rand_data());
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_valid", 128'(lcl_resp_valid), 128'(1));
        chk("bp_cnt", 128'(outstanding_cnt), 128'(MAX_OUT - 1));
        hold_rready = 1'b0;
        wait_idle("bp");

        // Reset asserted mid-flight, then a late DMA response.
        do_reset();
        hold_rready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) issue(IDW'(i), 1'b0, 64'h8000, '1);
        send_resp(4'd0, 2'b11, 3'd0, rand_data());
        send_resp(4'd1, 2'b01, 3'd0, rand_data());
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_pre_valid", 128'(lcl_resp_valid), 128'(1));
        @(posedge clk); #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk_reset_vals("mid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold_rready = 1'b0;
        send_resp(4'd1, 2'b10, 3'd0, rand_data());
        @(negedge clk);
        chk("late_fir", 128'(fir), 128'(exp_fir));
        wait_idle("mid");

        // Randomized traffic: random split/full, out-of-order, both sides stalled.
        do_reset();
        bp_en = 1'b1;
        issue_done = 1'b0;
        fork
            begin : issuer
                for (int i = 0; i < NRAND; i++) begin
                    issue(IDW'($urandom), 1'($urandom), {$urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom});
                end
                issue_done = 1'b1;
            end
            begin : responder
                int            k;
                int            guard;
                pend_t         p;
                logic [1:0]    pos;
                logic [2:0]    code;
                logic [DW-1:0] rd;
                guard = 0;
                while (!(issue_done && pend.size() == 0) && guard < 20000) begin
                    guard++;
                    @(posedge clk); #1;
                    dma_resp_valid = 1'b0;
                    if (pend.size() != 0 && $urandom_range(0, 1) == 1) begin
                        k = $urandom_range(0, pend.size() - 1);
                        p = pend[k];
                        if (p.rem == 2'b11 && $urandom_range(0, 2) == 0)
                            pos = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
                        else
                            pos = p.rem;
                        code = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                        rd = rand_data();
                        dma_resp_valid = 1'b1;
                        dma_resp_tag   = p.tag;
                        dma_resp_pos   = pos;
                        dma_resp_code  = code;
                        dma_resp_data  = rd;
                        model_resp(p.tag, pos, code, rd);
                        if (pos == p.rem) pend.delete(k);
                        else pend[k].rem = p.rem & ~pos;
                    end
                end
                @(posedge clk); #1;
                dma_resp_valid = 1'b0;
                if (guard >= 20000) begin
                    vec_cnt++;
                    miss_cnt++;
                    $display("FAIL rand_timeout: got %0d pending expected 0", pend.size());
                end
            end
        join
        bp_en = 1'b0;
        wait_idle("rand");
        chk("rand_fir", 128'(fir), 128'(exp_fir));
        chk("rand_cnt", 128'(outstanding_cnt), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
